// File: rtl/router_pkg.sv
// Shared types and defaults for the router start-request arbiter.
package router_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DFX_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } rarb_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] src_addr;
    logic [DEF_ADDR_W-1:0] dst_addr;
    logic [DEF_DFX_W-1:0]  src_dfx;
    logic [DEF_DFX_W-1:0]  dst_dfx;
  } route_req_t;

endpackage

// File: rtl/router_req_arbiter_if.sv
// Requester bus, router start-request port and response port of the arbiter.
interface router_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = router_pkg::DEF_ADDR_W,
  parameter int DFX_W   = router_pkg::DEF_DFX_W
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_src_addr;
  logic [NUM_REQ*ADDR_W-1:0] req_dst_addr;
  logic [NUM_REQ*DFX_W-1:0]  req_src_dfx;
  logic [NUM_REQ*DFX_W-1:0]  req_dst_dfx;
  logic                      router_start_req;
  logic [ADDR_W-1:0]         router_scr_addr;
  logic [ADDR_W-1:0]         router_dst_addr;
  logic [DFX_W-1:0]          router_src_dfx;
  logic [DFX_W-1:0]          router_dst_dfx;
  logic                      router_ack;
  logic                      rsp_valid;
  logic [IDX_W-1:0]          rsp_id;
  logic                      rsp_timeout;

  // arbiter side
  modport slave (
    input  req_valid, req_src_addr, req_dst_addr, req_src_dfx, req_dst_dfx, router_ack,
    output req_ready, router_start_req, router_scr_addr, router_dst_addr,
           router_src_dfx, router_dst_dfx, rsp_valid, rsp_id, rsp_timeout
  );

  // requester / router side
  modport master (
    output req_valid, req_src_addr, req_dst_addr, req_src_dfx, req_dst_dfx, router_ack,
    input  req_ready, router_start_req, router_scr_addr, router_dst_addr,
           router_src_dfx, router_dst_dfx, rsp_valid, rsp_id, rsp_timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, circularly.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt_onehot,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  // walk from ptr; NUM_REQ is a power of two so the index wraps by truncation
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_req_arbiter.sv
// Shares the single router start-request port among NUM_REQ requesters,
// one transaction at a time, with a per-transaction ack/timeout response.
module router_req_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DFX_W   = DEF_DFX_W,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  router_req_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  rarb_state_t state_q, state_d;

  logic [IDX_W-1:0]   rr_ptr_q, gnt_q, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_any, accept, tmo_hit;
  logic [TMO_W-1:0]   tmo_q;

  logic [NUM_REQ-1:0][ADDR_W-1:0] src_a, dst_a;
  logic [NUM_REQ-1:0][DFX_W-1:0]  src_d, dst_d;

  logic              start_q, rsp_valid_q, rsp_tmo_q;
  logic [ADDR_W-1:0] saddr_q, daddr_q;
  logic [DFX_W-1:0]  sdfx_q, ddfx_q;
  logic [IDX_W-1:0]  rsp_id_q;

  assign src_a = bus.req_src_addr;
  assign dst_a = bus.req_dst_addr;
  assign src_d = bus.req_src_dfx;
  assign dst_d = bus.req_dst_dfx;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // next state; ack beats expiry when both land in the same ISSUE cycle
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.router_ack) begin
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // accept pulse is the only combinational output
  assign bus.req_ready = accept ? pick_oh : '0;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // latch grant and routing fields at accept; start follows ISSUE occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      start_q <= 1'b0;
      saddr_q <= '0;
      daddr_q <= '0;
      sdfx_q  <= '0;
      ddfx_q  <= '0;
    end else begin
      start_q <= (state_d == ISSUE);
      if (accept) begin
        gnt_q   <= pick_idx;
        saddr_q <= src_a[pick_idx];
        daddr_q <= dst_a[pick_idx];
        sdfx_q  <= src_d[pick_idx];
        ddfx_q  <= dst_d[pick_idx];
      end
    end
  end

  // ISSUE cycle counter, zero on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= (state_q == ISSUE) ? tmo_q + 1'b1 : '0;
  end

  // response pulse and round-robin pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= (state_q == ISSUE) && (state_d == RESP);
      rsp_tmo_q   <= tmo_hit;
      if ((state_q == ISSUE) && (state_d == RESP)) rsp_id_q <= gnt_q;
      if (state_q == RESP) rr_ptr_q <= gnt_q + 1'b1;
    end
  end

  assign bus.router_start_req = start_q;
  assign bus.router_scr_addr  = saddr_q;
  assign bus.router_dst_addr  = daddr_q;
  assign bus.router_src_dfx   = sdfx_q;
  assign bus.router_dst_dfx   = ddfx_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_id           = rsp_id_q;
  assign bus.rsp_timeout      = rsp_tmo_q;

endmodule
